// File: rtl/xgmii_traffic_gen.sv
// XGMII 64-bit Ethernet test-frame generator: bursts of sequenced frames separated by idle IFG words.
// Define TXGEN_CRC_EN to append a real IEEE 802.3 FCS; without it the four FCS bytes are zero.
module xgmii_traffic_gen #(
  parameter int unsigned LEN_W     = 16,
  parameter int unsigned CNT_W     = 32,
  parameter logic [15:0] ETHERTYPE = 16'h88B5
) (
  input  logic             sys_clk,
  input  logic             sys_rst_n,
  input  logic             enable,
  input  logic [LEN_W-1:0] frame_len,
  input  logic [LEN_W-1:0] ifg_words,
  input  logic [CNT_W-1:0] burst_cnt,
  input  logic [47:0]      dst_mac,
  input  logic [47:0]      src_mac,
  output logic [63:0]      xgmii_txd,
  output logic [7:0]       xgmii_txc,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] tx_frames
);

  localparam logic [63:0] IDLE_WORD  = 64'h0707070707070707;
  localparam logic [63:0] START_WORD = 64'hD5555555555555FB;
  localparam logic [63:0] TERM_WORD  = 64'h07070707070707FD;

  typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_TERM, S_IFG, S_HOLD} state_t;
  state_t r_state, w_next;

  logic [LEN_W-1:0] r_len, r_ifg, r_pos, r_ifg_cnt;
  logic [CNT_W-1:0] r_burst, r_burst_sent, r_tx_frames;
  logic [47:0]      r_da, r_sa;
  logic [31:0]      r_seq;
  logic             r_done;

  logic [LEN_W-1:0] w_len_clamp, w_ifg_clamp, w_rem, w_pay_end;
  logic             w_new_burst, w_ifg_last, w_exhausted, w_latch, w_term;
  logic [143:0]     w_hdr;
  logic [LEN_W-1:0] w_lane_pos [8];
  logic [4:0]       w_hdr_sel  [8];
  logic [1:0]       w_fcs_idx  [8];
  logic [7:0]       w_byte     [8];
  logic [7:0]       w_is_data, w_is_fcs, w_is_end;
  logic [31:0]      w_fcs;

  assign w_len_clamp = (frame_len < LEN_W'(64))   ? LEN_W'(64)   :
                       (frame_len > LEN_W'(1518)) ? LEN_W'(1518) : frame_len;
  assign w_ifg_clamp = (ifg_words == '0) ? LEN_W'(1) : ifg_words;

  assign w_rem       = r_len - r_pos;
  assign w_pay_end   = r_len - LEN_W'(4);
  assign w_term      = ((r_state == S_DATA) && (w_rem < LEN_W'(8))) || (r_state == S_TERM);
  assign w_ifg_last  = (r_state == S_IFG) && (r_ifg_cnt == '0);
  assign w_exhausted = (r_burst != '0) && (r_burst_sent >= r_burst);
  assign w_new_burst = (r_state == S_IDLE) && enable;
  assign w_latch     = w_new_burst || (w_ifg_last && !w_exhausted && enable);
  assign w_hdr       = {r_da, r_sa, ETHERTYPE, r_seq};

  // Per-lane classification of the frame byte carried this cycle.
  always_comb begin
    w_is_data = '0;
    w_is_fcs  = '0;
    w_is_end  = '0;
    for (int unsigned i = 0; i < 8; i++) begin
      w_lane_pos[i] = r_pos + LEN_W'(i);
      w_hdr_sel[i]  = (w_lane_pos[i] < LEN_W'(18)) ? w_lane_pos[i][4:0] : 5'd0;
      w_byte[i]     = (w_lane_pos[i] < LEN_W'(18)) ? w_hdr[(17 - 32'(w_hdr_sel[i])) * 8 +: 8]
                                                   : w_lane_pos[i][7:0];
      w_fcs_idx[i]  = 2'(w_lane_pos[i] - w_pay_end);
      w_is_data[i]  = w_lane_pos[i] < w_pay_end;
      w_is_fcs[i]   = (w_lane_pos[i] >= w_pay_end) && (w_lane_pos[i] < r_len);
      w_is_end[i]   = w_lane_pos[i] == r_len;
    end
  end

`ifdef TXGEN_CRC_EN
  logic [31:0] r_crc, w_crc_next;

  function automatic logic [31:0] crc32_byte(input logic [31:0] c, input logic [7:0] d);
    logic [31:0] x;
    x = c ^ {24'd0, d};
    for (int unsigned k = 0; k < 8; k++)
      x = x[0] ? ((x >> 1) ^ 32'hEDB88320) : (x >> 1);
    return x;
  endfunction

  // FCS lanes always follow every data lane of the same word, so the inverted running
  // CRC including this word's data is valid for any FCS byte emitted this cycle.
  always_comb begin
    w_crc_next = r_crc;
    for (int unsigned i = 0; i < 8; i++)
      if (w_is_data[i]) w_crc_next = crc32_byte(w_crc_next, w_byte[i]);
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n)                r_crc <= '1;
    else if (r_state == S_START)   r_crc <= '1;
    else if (r_state == S_DATA)    r_crc <= w_crc_next;
  end

  assign w_fcs = ~w_crc_next;
`else
  assign w_fcs = '0;
`endif

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) r_state <= S_IDLE;
    else            r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (enable) w_next = S_START;
      S_START: w_next = S_DATA;
      S_DATA: begin
        if (w_rem == LEN_W'(8))     w_next = S_TERM;
        else if (w_rem < LEN_W'(8)) w_next = S_IFG;
      end
      S_TERM:  w_next = S_IFG;
      S_IFG:   if (w_ifg_last) w_next = w_exhausted ? S_HOLD : (enable ? S_START : S_IDLE);
      S_HOLD:  if (!enable) w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_len        <= LEN_W'(64);
      r_ifg        <= LEN_W'(1);
      r_pos        <= '0;
      r_ifg_cnt    <= '0;
      r_burst      <= '0;
      r_burst_sent <= '0;
      r_tx_frames  <= '0;
      r_da         <= '0;
      r_sa         <= '0;
      r_seq        <= '0;
      r_done       <= 1'b0;
    end else begin
      r_done <= w_ifg_last && w_exhausted;
      if (w_latch) begin
        r_len   <= w_len_clamp;
        r_ifg   <= w_ifg_clamp;
        r_burst <= burst_cnt;
        r_da    <= dst_mac;
        r_sa    <= src_mac;
      end
      if (w_new_burst) r_burst_sent <= '0;
      else if (w_term) r_burst_sent <= r_burst_sent + CNT_W'(1);
      if (w_term) begin
        r_seq       <= r_seq + 32'd1;
        r_tx_frames <= r_tx_frames + CNT_W'(1);
        r_ifg_cnt   <= r_ifg - LEN_W'(1);
      end else if ((r_state == S_IFG) && (r_ifg_cnt != '0)) begin
        r_ifg_cnt <= r_ifg_cnt - LEN_W'(1);
      end
      if (r_state == S_START)     r_pos <= '0;
      else if (r_state == S_DATA) r_pos <= r_pos + LEN_W'(8);
    end
  end

  always_comb begin
    xgmii_txd = IDLE_WORD;
    xgmii_txc = '1;
    busy      = 1'b0;
    case (r_state)
      S_START: begin
        xgmii_txd = START_WORD;
        xgmii_txc = 8'h01;
        busy      = 1'b1;
      end
      S_DATA: begin
        busy = 1'b1;
        for (int unsigned i = 0; i < 8; i++) begin
          if (w_is_data[i]) begin
            xgmii_txd[8*i +: 8] = w_byte[i];
            xgmii_txc[i]        = 1'b0;
          end else if (w_is_fcs[i]) begin
            xgmii_txd[8*i +: 8] = w_fcs[8*w_fcs_idx[i] +: 8];
            xgmii_txc[i]        = 1'b0;
          end else if (w_is_end[i]) begin
            xgmii_txd[8*i +: 8] = 8'hFD;
          end
        end
      end
      S_TERM: begin
        xgmii_txd = TERM_WORD;
        busy      = 1'b1;
      end
      S_IFG:   busy = 1'b1;
      default: ;
    endcase
  end

  assign done      = r_done;
  assign tx_frames = r_tx_frames;

endmodule

// File: tb/tb_xgmii_traffic_gen.sv
// Self-checking bench for xgmii_traffic_gen: expected XGMII word streams are built from
// frame byte lists (header, pattern, FCS, terminate, padding) and compared cycle by cycle.
`timescale 1ns/1ps
module tb_xgmii_traffic_gen;
  localparam int LEN_W = 16;
  localparam int CNT_W = 32;
  localparam logic [63:0] IDLE_W  = 64'h0707070707070707;
  localparam logic [63:0] START_W = 64'hD5555555555555FB;

  logic             sys_clk = 1'b0;
  logic             sys_rst_n, enable;
  logic [LEN_W-1:0] frame_len, ifg_words;
  logic [CNT_W-1:0] burst_cnt;
  logic [47:0]      dst_mac, src_mac;
  logic [63:0]      xgmii_txd;
  logic [7:0]       xgmii_txc;
  logic             busy, done;
  logic [CNT_W-1:0] tx_frames;

  xgmii_traffic_gen #(.LEN_W(LEN_W), .CNT_W(CNT_W), .ETHERTYPE(16'h88B5)) dut (
    .sys_clk(sys_clk), .sys_rst_n(sys_rst_n), .enable(enable), .frame_len(frame_len),
    .ifg_words(ifg_words), .burst_cnt(burst_cnt), .dst_mac(dst_mac), .src_mac(src_mac),
    .xgmii_txd(xgmii_txd), .xgmii_txc(xgmii_txc), .busy(busy), .done(done),
    .tx_frames(tx_frames)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct { logic [63:0] d; logic [7:0] c; logic b; } word_t;
  typedef struct { int len; int ifg; int burst; int exp_term; } vec_t;

  word_t       exp_q[$];
  word_t       obs_q[$];
  int          tests = 0;
  int          fails = 0;
  int          done_seen = 0;
  int          frames_m = 0;
  logic [31:0] seq_m = 0;
  logic [31:0] last_fcs_m = 0;

  always @(posedge sys_clk) if (done === 1'b1) done_seen++;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

  task automatic step();
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h required %h", name, act, exp);
    end
  endtask

  function automatic bit has_term(input logic [63:0] d, input logic [7:0] c);
    for (int j = 0; j < 8; j++)
      if (c[j] && d[8*j +: 8] == 8'hFD) return 1'b1;
    return 1'b0;
  endfunction

  // Reference: one frame's START word, data/FCS/terminate words, then IFG idles.
  task automatic model_frame(input int len_raw, input int ifg_raw, input logic [47:0] da,
                             input logic [47:0] sa, input logic [31:0] seq);
    int L, g;
    logic [7:0]   fb[$];
    logic [8:0]   ls[$];
    logic [31:0]  crc;
    logic [143:0] hdr;
    word_t        w;
    L = (len_raw < 64) ? 64 : (len_raw > 1518) ? 1518 : len_raw;
    g = (ifg_raw < 1) ? 1 : ifg_raw;
    hdr = {da, sa, 16'h88B5, seq};
    for (int n = 0; n < L - 4; n++)
      if (n < 18) fb.push_back(hdr[143 - 8*n -: 8]);
      else        fb.push_back(8'(n));
    crc = 32'hFFFFFFFF;
`ifdef TXGEN_CRC_EN
    foreach (fb[i]) begin
      crc = crc ^ {24'd0, fb[i]};
      for (int k = 0; k < 8; k++) crc = crc[0] ? ((crc >> 1) ^ 32'hEDB88320) : (crc >> 1);
    end
    crc = ~crc;
`else
    crc = 32'd0;
`endif
    last_fcs_m = crc;
    for (int k = 0; k < 4; k++) fb.push_back(crc[8*k +: 8]);
    w.d = START_W; w.c = 8'h01; w.b = 1'b1;
    exp_q.push_back(w);
    foreach (fb[i]) ls.push_back({1'b0, fb[i]});
    ls.push_back({1'b1, 8'hFD});
    while (ls.size() % 8 != 0) ls.push_back({1'b1, 8'h07});
    for (int i = 0; i < ls.size(); i += 8) begin
      for (int j = 0; j < 8; j++) begin
        w.d[8*j +: 8] = ls[i+j][7:0];
        w.c[j]        = ls[i+j][8];
      end
      w.b = 1'b1;
      exp_q.push_back(w);
    end
    for (int i = 0; i < g; i++) begin
      w.d = IDLE_W; w.c = 8'hFF; w.b = 1'b1;
      exp_q.push_back(w);
    end
  endtask

  task automatic check_stream(input string name, input int drop_idx, input bit scramble,
                              output int term_words);
    int t, bad;
    word_t w;
    obs_q.delete();
    term_words = -1;
    bad = -1;
    t = 0;
    while (!(xgmii_txd == START_W && xgmii_txc == 8'h01) && t < 64) begin
      step();
      t++;
    end
    tests++;
    if (!(xgmii_txd == START_W && xgmii_txc == 8'h01)) begin
      fails++;
      $display("FAIL %s_start: no start word in 64 cycles, got %h required %h", name, xgmii_txd, START_W);
      return;
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i > 0) step();
      w.d = xgmii_txd; w.c = xgmii_txc; w.b = busy;
      obs_q.push_back(w);
      if (bad < 0 && (w.d !== exp_q[i].d || w.c !== exp_q[i].c || w.b !== exp_q[i].b)) bad = i;
      if (term_words < 0 && i > 0 && has_term(w.d, w.c)) term_words = i;
      if (i == drop_idx) enable = 1'b0;
      if (scramble && i == 0) begin
        frame_len = LEN_W'($urandom);
        ifg_words = LEN_W'($urandom);
        burst_cnt = CNT_W'($urandom);
        dst_mac   = 48'({$urandom(), $urandom()});
        src_mac   = 48'({$urandom(), $urandom()});
      end
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      $display("FAIL %s_stream: word %0d got txd=%h txc=%h busy=%b required txd=%h txc=%h busy=%b",
               name, bad, obs_q[bad].d, obs_q[bad].c, obs_q[bad].b,
               exp_q[bad].d, exp_q[bad].c, exp_q[bad].b);
    end
  endtask

  task automatic run_burst(input string name, input int len, input int ifg, input int burst,
                           input logic [47:0] da, input logic [47:0] sa, input bit scramble,
                           output int term_words);
    int d0;
    exp_q.delete();
    for (int f = 0; f < burst; f++) begin
      model_frame(len, ifg, da, sa, seq_m);
      seq_m++;
      frames_m++;
    end
    frame_len = LEN_W'(len);
    ifg_words = LEN_W'(ifg);
    burst_cnt = CNT_W'(burst);
    dst_mac   = da;
    src_mac   = sa;
    d0        = done_seen;
    enable    = 1'b1;
    check_stream(name, -1, scramble, term_words);
    step();
    check({name, "_done"}, 64'(done), 64'd1);
    check({name, "_hold_txd"}, xgmii_txd, IDLE_W);
    check({name, "_hold_busy"}, 64'(busy), 64'd0);
    check({name, "_tx_frames"}, 64'(tx_frames), 64'(frames_m));
    enable = 1'b0;
    step();
    step();
    check({name, "_done_count"}, 64'(done_seen - d0), 64'd1);
    check({name, "_idle_txc"}, 64'(xgmii_txc), 64'hFF);
  endtask

  initial begin
    vec_t vecs[6];
    int tw, len, ifg, burst, d0;
    logic [47:0] da, sa;

    vecs[0] = '{len: 64,   ifg: 1, burst: 1, exp_term: 9};
    vecs[1] = '{len: 60,   ifg: 1, burst: 1, exp_term: 9};
    vecs[2] = '{len: 65,   ifg: 2, burst: 3, exp_term: 9};
    vecs[3] = '{len: 72,   ifg: 0, burst: 1, exp_term: 10};
    vecs[4] = '{len: 1518, ifg: 3, burst: 1, exp_term: 190};
    vecs[5] = '{len: 2000, ifg: 1, burst: 2, exp_term: 190};

    sys_rst_n = 1'b0; enable = 1'b0;
    frame_len = 16'd64; ifg_words = 16'd1; burst_cnt = 32'd1;
    dst_mac = 48'h0A1B2C3D4E5F; src_mac = 48'h665544332211;
    step();
    step();
    check("rst_txd", xgmii_txd, IDLE_W);
    check("rst_txc", 64'(xgmii_txc), 64'hFF);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_done", 64'(done), 64'd0);
    check("rst_tx_frames", 64'(tx_frames), 64'd0);
    sys_rst_n = 1'b1;
    step();

    foreach (vecs[v]) begin
      run_burst($sformatf("vec%0d", v), vecs[v].len, vecs[v].ifg, vecs[v].burst,
                48'h0A1B2C3D4E5F, 48'h665544332211, 1'b0, tw);
      check($sformatf("vec%0d_term_pos", v), 64'(tw), 64'(vecs[v].exp_term));
    end

    // CRC frame with broadcast DA: FCS in lanes 4..7 of the eighth data word.
    run_burst("crc", 64, 1, 1, 48'hFFFFFFFFFFFF, 48'h001122334455, 1'b0, tw);
    if (obs_q.size() > 8) check("crc_fcs", 64'(obs_q[8].d[63:32]), 64'(last_fcs_m));
    else check("crc_fcs_words", 64'(obs_q.size()), 64'd9);

    // Continuous mode, enable dropped during the 5th data word of frame 4.
    exp_q.delete();
    for (int f = 0; f < 4; f++) begin
      model_frame(100, 2, 48'h111111111111, 48'h222222222222, seq_m);
      seq_m++;
      frames_m++;
    end
    frame_len = 16'd100; ifg_words = 16'd2; burst_cnt = 32'd0;
    dst_mac = 48'h111111111111; src_mac = 48'h222222222222;
    d0 = done_seen;
    enable = 1'b1;
    check_stream("cont", 3 * 16 + 5, 1'b0, tw);
    step();
    check("cont_idle_txd", xgmii_txd, IDLE_W);
    check("cont_busy", 64'(busy), 64'd0);
    check("cont_tx_frames", 64'(tx_frames), 64'(frames_m));
    for (int i = 0; i < 5; i++) step();
    check("cont_stays_idle", xgmii_txd, IDLE_W);
    check("cont_no_done", 64'(done_seen - d0), 64'd0);

    // Randomized bursts; single-frame bursts also scramble config after START.
    for (int r = 0; r < 12; r++) begin
      len   = int'($urandom_range(40, 400));
      ifg   = int'($urandom_range(0, 3));
      burst = int'($urandom_range(1, 3));
      da    = 48'({$urandom(), $urandom()});
      sa    = 48'({$urandom(), $urandom()});
      run_burst($sformatf("rnd%0d", r), len, ifg, burst, da, sa, burst == 1, tw);
    end

    // Asynchronous reset in the middle of a frame.
    frame_len = 16'd200; ifg_words = 16'd1; burst_cnt = 32'd1;
    dst_mac = 48'h0A1B2C3D4E5F; src_mac = 48'h665544332211;
    enable = 1'b1;
    tw = 0;
    while (!(xgmii_txd == START_W && xgmii_txc == 8'h01) && tw < 64) begin
      step();
      tw++;
    end
    step(); step(); step();
    check("mid_busy_before_rst", 64'(busy), 64'd1);
    sys_rst_n = 1'b0;
    #1;
    check("arst_txd", xgmii_txd, IDLE_W);
    check("arst_txc", 64'(xgmii_txc), 64'hFF);
    check("arst_busy", 64'(busy), 64'd0);
    check("arst_tx_frames", 64'(tx_frames), 64'd0);
    step();
    check("arst_hold_txd", xgmii_txd, IDLE_W);
    sys_rst_n = 1'b1;
    seq_m = 0;
    frames_m = 0;
    run_burst("post_rst", 64, 1, 1, 48'h0A1B2C3D4E5F, 48'h665544332211, 1'b0, tw);
    if (obs_q.size() > 3) check("post_rst_seq0", 64'(obs_q[2].d[55:48]) | 64'(obs_q[3].d[7:0]), 64'd0);
    else check("post_rst_words", 64'(obs_q.size()), 64'd11);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/xgmii_traffic_gen.md
XGMII_TRAFFIC_GEN -- requirements
Module: xgmii_traffic_gen

Interface
REQ-001 The block SHALL have parameter LEN_W, default 16, frame-length and IFG field width.
REQ-002 The block SHALL have parameter CNT_W, default 32, burst-count and frame-counter width.
REQ-003 The block SHALL have parameter ETHERTYPE, default 16'h88B5, the ethertype inserted at payload bytes 12-13.
REQ-004 Port sys_clk, input, 1, the 156.25 MHz XGMII clock; sole clock.
REQ-005 Port sys_rst_n, input, 1, asynchronous active-low reset.
REQ-006 Port enable, input, 1, level; generation runs while high.
REQ-007 Port frame_len, input, LEN_W, frame bytes from DA through FCS.
REQ-008 Port ifg_words, input, LEN_W, idle 64-bit words after the terminate word.
REQ-009 Port burst_cnt, input, CNT_W, frames per burst; 0 means continuous.
REQ-010 Port dst_mac / src_mac, input, 48 each, MAC addresses.
REQ-011 Port xgmii_txd, output, 64, XGMII data; lane 0 = bits 7:0, first on wire.
REQ-012 Port xgmii_txc, output, 8, XGMII control, one bit per lane.
REQ-013 Port busy, output, 1, high from the first start word through the last IFG word.
REQ-014 Port done, output, 1, one-cycle pulse when a burst completes.
REQ-015 Port tx_frames, output, CNT_W, frames sent since reset; wraps.

Function
REQ-016 Idle word SHALL be txd=64'h0707070707070707, txc=8'hFF.
REQ-017 States SHALL be IDLE, START, DATA, TERM, IFG, HOLD.
REQ-018 IDLE->START when enable=1; frame_len, ifg_words, burst_cnt and MACs latch on that transition.
REQ-019 Latched frame_len SHALL clamp to 64..1518; latched ifg_words SHALL clamp to a minimum of 1.
REQ-020 START word SHALL be txd=64'hD5555555555555FB, txc=8'h01, one cycle.
REQ-021 Payload SHALL carry bytes 0-5 DA and 6-11 SA (MSB first), 12-13 ETHERTYPE, 14-17 a 32-bit sequence number (big-endian), byte n>=18 = n[7:0], and the last 4 bytes FCS.
REQ-022 DATA SHALL emit 8 payload bytes per cycle with txc=0 for data lanes.
REQ-023 Terminate 0xFD (txc=1) SHALL occupy the lane after the last FCS byte, with higher lanes idle 0x07 (txc=1), in the same word as the final data.
REQ-024 If frame_len is a multiple of 8, TERM SHALL emit a separate word txd=64'h07070707070707FD, txc=8'hFF.
REQ-025 IFG SHALL emit exactly the latched ifg_words idle words.
REQ-026 tx_frames and the sequence number SHALL increment on the terminate word; the sequence number starts at 0 after reset.
REQ-027 After IFG: if enable=1 and burst not exhausted -> START with no extra idle and re-latched config; if burst exhausted -> HOLD with done pulsed one cycle; if enable=0 -> IDLE.
REQ-028 HOLD SHALL emit idle and go to IDLE when enable=0; a new burst requires an enable low-then-high.
REQ-029 Deassertion of enable mid-frame SHALL NOT truncate the frame; the frame and its IFG complete first.
REQ-030 Config changes mid-frame SHALL have no effect until the next START.

Reset
REQ-031 On sys_rst_n=0: state IDLE, outputs idle word, busy=0, done=0, tx_frames=0, sequence number 0, burst counter 0.
REQ-032 Reset asserted mid-frame SHALL force the idle word immediately (asynchronous); no terminate is emitted.

Configuration
REQ-033 Macro TXGEN_CRC_EN: when defined, FCS SHALL be the IEEE 802.3 CRC-32 over DA..last payload byte, transmitted LSB-byte first; when undefined, the FCS bytes SHALL be 8'h00 and no CRC logic is present.

Verification
REQ-034 frame_len=64, ifg_words=1, burst_cnt=1, enable held high -> START word, 8 DATA words, TERM word 07070707070707FD/FF, 1 idle, done pulse, tx_frames=1, HOLD.
REQ-035 frame_len=60 -> clamped to 64; output identical to REQ-034.
REQ-036 frame_len=65, burst_cnt=3, ifg_words=2 -> 3 frames with lane-1 terminate in the 9th data word, 2 idles between frames, sequence numbers 0,1,2, done once, tx_frames=3.
REQ-037 burst_cnt=0, enable dropped during the 5th data word of frame 4 -> frame 4 completes with its IFG, then IDLE; tx_frames=4, no done pulse.
REQ-038 TXGEN_CRC_EN defined, DA=FF:FF:FF:FF:FF:FF, SA=00:11:22:33:44:55, len 64 -> FCS matches a software CRC-32 reference; undefined -> FCS=00000000.
REQ-039 sys_rst_n pulsed low mid-DATA -> next edge idle word, busy=0, tx_frames=0; after release with enable=1, a fresh frame with sequence number 0.
